// File: rtl/hardware_debinarize_stream.sv
// Heap-word to SKI-term decoder with a 2-entry output FIFO and illegal-word tracking.
// Latency: an accepted legal word is visible on ski_o one cycle later if the buffer was empty.
// Backpressure: word_ready_o drops when both buffer entries are occupied; it never depends on ski_ready_i.
// Optional: define CHECK_PADDING_EN to also reject words whose unused payload bits are non-zero.
module hardware_debinarize_stream #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 system1000,
  input  logic                 system1000_rst,
  input  logic [63:0]          word_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  output logic [62:0]          ski_o,
  output logic                 ski_valid_o,
  input  logic                 ski_ready_i,
  output logic                 err_pulse_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
);

  logic [3:0]  tag;
  logic        legal;
  logic [62:0] term;

  logic [62:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  occ;

  logic        accept;
  logic        push;
  logic        pop;
  logic        bad;

  assign tag = word_i[63:60];

  // Translate the heap tag into a constructor and repack the payload fields.
  always_comb begin
    legal = 1'b1;
    term  = '0;
    case (tag)
      4'h0: term = {3'b000, 60'b0};
      4'h1: term = {3'b001, 60'b0};
      4'h2: term = {3'b010, 60'b0};
      4'h3: term = {3'b011, word_i[59:30], word_i[29:0]};
      4'h4: term = {3'b100, word_i[31:0], 28'b0};
      default: legal = 1'b0;
    endcase
`ifdef CHECK_PADDING_EN
    // Atoms must carry an all-zero payload; literals only use the low 32 bits.
    if ((tag <= 4'h2) && (word_i[59:0] != 60'b0)) legal = 1'b0;
    if ((tag == 4'h4) && (word_i[59:32] != 28'b0)) legal = 1'b0;
`endif
  end

  // Ready comes from registered occupancy so the producer never sees a path from the consumer.
  assign word_ready_o = ~system1000_rst & (occ != 2'd2);
  assign ski_valid_o  = (occ != 2'd0);
  assign ski_o        = mem[rd_ptr];

  assign accept = word_valid_i & word_ready_o;
  assign push   = accept & legal;
  assign bad    = accept & ~legal;
  assign pop    = ski_valid_o & ski_ready_i;

  // Two-entry circular buffer; reset zeroes the storage so ski_o reads 0 out of reset.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= term;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // Illegal-word bookkeeping: a fresh error always survives a simultaneous clear.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      err_pulse_o  <= 1'b0;
      err_sticky_o <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      err_pulse_o <= bad;
      if (bad) begin
        err_sticky_o <= 1'b1;
        if (err_clr_i) begin
          err_cnt_o <= ERR_CNT_W'(1);
        end else if (err_cnt_o != {ERR_CNT_W{1'b1}}) begin
          err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
      end else if (err_clr_i) begin
        err_sticky_o <= 1'b0;
        err_cnt_o    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hardware_debinarize_stream.sv
// Randomized bench for hardware_debinarize_stream with a queue-based reference model.
// Directed vectors first (decode cases, backpressure, errors, reset with buffered data), then random phases.
// A narrow error counter is used so saturation is reached quickly.
module tb_hardware_debinarize_stream;

  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [63:0]   word;
  logic          word_valid;
  logic          word_ready;
  logic [62:0]   ski;
  logic          ski_valid;
  logic          ski_ready;
  logic          err_pulse;
  logic          err_sticky;
  logic [CW-1:0] err_cnt;
  logic          err_clr;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [62:0] q[$];
  int          m_cnt    = 0;
  bit          m_sticky = 0;
  bit          m_pulse  = 0;

  hardware_debinarize_stream #(.ERR_CNT_W(CW)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .word_i         (word),
    .word_valid_i   (word_valid),
    .word_ready_o   (word_ready),
    .ski_o          (ski),
    .ski_valid_o    (ski_valid),
    .ski_ready_i    (ski_ready),
    .err_pulse_o    (err_pulse),
    .err_sticky_o   (err_sticky),
    .err_cnt_o      (err_cnt),
    .err_clr_i      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Legality straight from the tag table (plus padding rules when enabled).
  function automatic bit ref_legal(input logic [63:0] w);
    int t = int'(w[63:60]);
    bit ok = (t <= 4);
`ifdef CHECK_PADDING_EN
    if (t <= 2 && w[59:0] != 60'd0) ok = 0;
    if (t == 4 && w[59:32] != 28'd0) ok = 0;
`endif
    return ok;
  endfunction

  // Term value built arithmetically: constructor code in the top 3 bits, fields below.
  function automatic logic [62:0] ref_term(input logic [63:0] w);
    logic [62:0] ctor = 63'(w[63:60]) << 60;
    if (w[63:60] == 4'h3) return ctor | 63'(w[59:0]);
    if (w[63:60] == 4'h4) return ctor | (63'(w[31:0]) << 28);
    return ctor;
  endfunction

  // Called at a negedge: drive inputs, check, advance model, then move to the next negedge.
  task automatic step(input logic v, input logic [63:0] w, input logic r,
                      input logic c, input logic rs);
    bit acc;
    bit pop;
    word = w; word_valid = v; ski_ready = r; err_clr = c; rst = rs;
    #1;
    check_val("word_ready", 64'(word_ready), 64'(!rs && q.size() < 2));
    check_val("ski_valid",  64'(ski_valid),  64'(q.size() != 0));
    if (q.size() != 0) check_val("ski_data", 64'(ski), 64'(q[0]));
    check_val("err_pulse",  64'(err_pulse),  64'(m_pulse));
    check_val("err_sticky", 64'(err_sticky), 64'(m_sticky));
    check_val("err_cnt",    64'(err_cnt),    64'(m_cnt));
    if (rs) begin
      q.delete(); m_cnt = 0; m_sticky = 0; m_pulse = 0;
    end else begin
      acc = v && (q.size() < 2);
      pop = (q.size() != 0) && r;
      if (pop) void'(q.pop_front());
      if (acc && ref_legal(w)) q.push_back(ref_term(w));
      m_pulse = acc && !ref_legal(w);
      if (m_pulse) begin
        m_sticky = 1;
        m_cnt = c ? 1 : ((m_cnt < CNTMAX) ? m_cnt + 1 : CNTMAX);
      end else if (c) begin
        m_sticky = 0; m_cnt = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_word(input int p_illegal);
    logic [3:0]  t;
    logic [59:0] pl;
    if ($urandom_range(99) < p_illegal) t = 4'($urandom_range(15, 5));
    else t = 4'($urandom_range(4, 0));
    pl = 60'({$urandom, $urandom});
    if ($urandom_range(1) == 0) begin
      if (t <= 4'h2) pl = '0;
      if (t == 4'h4) pl[59:32] = '0;
    end
    return {t, pl};
  endfunction

  initial begin
    int p_v, p_r, p_ill, p_clr, p_rst;
    rst = 1'b1; word = '0; word_valid = 0; ski_ready = 0; err_clr = 0;
    @(posedge clk);
    @(negedge clk);
    step(0, 64'd0, 0, 0, 1);

    // Pointer pair decode, then the four non-pointer constructors back to back.
    step(1, 64'h3000_0001_4000_0002, 1, 0, 0);
    step(1, 64'h0000_0000_0000_0000, 1, 0, 0);
    step(1, 64'h1000_0000_0000_0000, 1, 0, 0);
    step(1, 64'h2000_0000_0000_0000, 1, 0, 0);
    step(1, 64'h4000_0000_DEAD_BEEF, 1, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    // Backpressure: third word refused until the consumer drains.
    step(1, 64'h3000_0000_0000_0011, 0, 0, 0);
    step(1, 64'h3000_0000_0000_0022, 0, 0, 0);
    step(1, 64'h3000_0000_0000_0033, 0, 0, 0);
    step(1, 64'h3000_0000_0000_0033, 1, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    // Illegal tag, then illegal with clear, then saturation.
    step(1, 64'h7000_0000_0000_0000, 1, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    step(1, 64'h9000_0000_0000_0000, 1, 1, 0);
    step(0, 64'd0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 64'hF000_0000_0000_0001, 1, 0, 0);
    step(0, 64'd0, 1, 1, 0);
    // Atom with a stray payload bit (padding-dependent outcome).
    step(1, 64'h0000_0000_0000_0020, 1, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    // Reset with two terms buffered.
    step(1, 64'h1000_0000_0000_0000, 0, 0, 0);
    step(1, 64'h2000_0000_0000_0000, 0, 0, 0);
    step(0, 64'd0, 0, 0, 1);
    step(0, 64'd0, 1, 0, 0);

    // Random phases: balanced, heavy backpressure, error-heavy with clears, resets sprinkled.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin p_v = 80; p_r = 80; p_ill = 10; p_clr = 2;  p_rst = 0; end
        1: begin p_v = 90; p_r = 25; p_ill = 10; p_clr = 2;  p_rst = 0; end
        2: begin p_v = 70; p_r = 70; p_ill = 60; p_clr = 10; p_rst = 0; end
        default: begin p_v = 70; p_r = 60; p_ill = 20; p_clr = 5; p_rst = 3; end
      endcase
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(99) < p_v, rand_word(p_ill), $urandom_range(99) < p_r,
             $urandom_range(99) < p_clr, $urandom_range(99) < p_rst);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
